elbeth_exception_unit: RTL and testbench

Pipeline-side trap controller sitting directly upstream of the CSR register file. It carries per-instruction exception flags down the IF/ID/EX/MEM stage registers and resolves them precisely at the MEM (commit) stage. It drives the CSR's `exception`, `exception_code`, `exception_pc`, `exception_load_addr`, `eret` and `retire` inputs. It also flushes the younger stages and redirects fetch to the CSR-provided `handler_pc` or `epc`.

---
 rtl/elbeth_exception_unit_pkg.sv | 52 +++++
 rtl/elbeth_exception_unit_if.sv | 56 +++++
 rtl/elbeth_exc_stage_reg.sv | 43 ++++
 rtl/elbeth_exception_unit.sv | 181 ++++++++++++++++++
 tb/tb_elbeth_exception_unit.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/elbeth_exception_unit_pkg.sv
// Shared definitions for the elbeth trap controller: cause codes, privilege
// encodings, FSM states and the per-stage exception record.
package elbeth_exception_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ECODE_INST_MISALIGNED = 4'd0;
  localparam logic [3:0] ECODE_INST_FAULT      = 4'd1;
  localparam logic [3:0] ECODE_ILLEGAL         = 4'd2;
  localparam logic [3:0] ECODE_BREAKPOINT      = 4'd3;
  localparam logic [3:0] ECODE_LD_MISALIGNED   = 4'd4;
  localparam logic [3:0] ECODE_LD_FAULT        = 4'd5;
  localparam logic [3:0] ECODE_ST_MISALIGNED   = 4'd6;
  localparam logic [3:0] ECODE_ST_FAULT        = 4'd7;
  localparam logic [3:0] ECODE_ECALL_BASE      = 4'd8;

  localparam logic [1:0] PRV_U = 2'd0;
  localparam logic [1:0] PRV_S = 2'd1;
  localparam logic [1:0] PRV_M = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_HOLD     = 2'd2
  } state_e;

  typedef struct packed {
    logic            valid;
    logic            exc;
    logic [3:0]      code;
    logic            is_eret;
    logic [XLEN-1:0] pc;
  } stage_t;

  localparam stage_t STAGE_EMPTY = '0;

  // Environment-call cause depends on the privilege the call was made from.
  function automatic logic [3:0] ecall_code(input logic [1:0] prv);
    case (prv)
      PRV_U:   return ECODE_ECALL_BASE;
      PRV_S:   return ECODE_ECALL_BASE + 4'd1;
      PRV_M:   return ECODE_ECALL_BASE + 4'd3;
      default: return ECODE_ECALL_BASE + {2'b00, prv};
    endcase
  endfunction

  // Data-side causes report the faulting data address instead of the PC.
  function automatic logic is_data_cause(input logic [3:0] code);
    return code[3:2] == 2'b01;
  endfunction

endpackage

// File: rtl/elbeth_exception_unit_if.sv
// Pipeline/CSR-facing signal bundle of the elbeth trap controller.
// slave: the exception unit itself; master: the surrounding pipeline and CSR file.
interface elbeth_exception_unit_if;
  import elbeth_exception_unit_pkg::*;

  logic            stall;
  logic            if_valid;
  logic            if_misaligned;
  logic            if_fault;
  logic [XLEN-1:0] if_pc;
  logic            id_illegal;
  logic            id_ecall;
  logic            id_ebreak;
  logic            id_eret;
  logic            id_csr_illegal;
  logic            mem_ld_misaligned;
  logic            mem_ld_fault;
  logic            mem_st_misaligned;
  logic            mem_st_fault;
  logic [XLEN-1:0] mem_addr;
  logic [1:0]      prv;
  logic            irq_pending;
  logic [XLEN-1:0] handler_pc;
  logic [XLEN-1:0] epc;
  logic            if_ready;

  logic            exception;
  logic [3:0]      exception_code;
  logic [XLEN-1:0] exception_pc;
  logic [XLEN-1:0] exception_load_addr;
  logic            interrupt_take;
  logic            eret;
  logic            retire;
  logic            flush;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output stall, if_valid, if_misaligned, if_fault, if_pc,
           id_illegal, id_ecall, id_ebreak, id_eret, id_csr_illegal,
           mem_ld_misaligned, mem_ld_fault, mem_st_misaligned, mem_st_fault,
           mem_addr, prv, irq_pending, handler_pc, epc, if_ready,
    input  exception, exception_code, exception_pc, exception_load_addr,
           interrupt_take, eret, retire, flush, redirect_valid, redirect_pc
  );

  modport slave (
    input  stall, if_valid, if_misaligned, if_fault, if_pc,
           id_illegal, id_ecall, id_ebreak, id_eret, id_csr_illegal,
           mem_ld_misaligned, mem_ld_fault, mem_st_misaligned, mem_st_fault,
           mem_addr, prv, irq_pending, handler_pc, epc, if_ready,
    output exception, exception_code, exception_pc, exception_load_addr,
           interrupt_take, eret, retire, flush, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/elbeth_exc_stage_reg.sv
// One pipeline stage of exception flags: holds on stall, clears on flush/rst,
// and only records a new cause if the instruction does not already carry one.
module elbeth_exc_stage_reg
  import elbeth_exception_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       flush,
  input  stage_t     d_i,
  input  logic       add_exc_i,
  input  logic [3:0] add_code_i,
  input  logic       add_eret_i,
  output stage_t     q_o
);

  stage_t entry_q, entry_d;

  always_comb begin
    entry_d = d_i;
    if (!d_i.valid) begin
      entry_d = STAGE_EMPTY;
    end else begin
      if (add_exc_i && !d_i.exc) begin
        entry_d.exc  = 1'b1;
        entry_d.code = add_code_i;
      end
      if (add_eret_i) entry_d.is_eret = 1'b1;
    end
  end

  // NOTE: sequential state uses <= so all stage registers sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      entry_q <= STAGE_EMPTY;
    end else if (!stall) begin
      entry_q <= entry_d;
    end
  end

  assign q_o = entry_q;

endmodule

// File: rtl/elbeth_exception_unit.sv
// Precise trap controller: carries causes IF->ID->EX->MEM, resolves them at commit
// and redirects fetch. Define ELBETH_INTERRUPT_EN to honour irq_pending.
module elbeth_exception_unit
  import elbeth_exception_unit_pkg::*;
(
  input logic                     clk,
  input logic                     rst,
  elbeth_exception_unit_if.slave  bus
);

  stage_t          if_entry, id_q, ex_q, mem_q;
  logic            id_exc;
  logic [3:0]      id_code;
  logic            mem_exc;
  logic [3:0]      mem_code;
  logic            irq_req;

  state_e          state_q, state_d;
  logic            tgt_epc_q, tgt_epc_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic [XLEN-1:0] target_pc;

  logic            exception_s, interrupt_s, eret_s, retire_s, flush_s;

  // Fetch-side causes, misalignment taking precedence over an access fault.
  always_comb begin
    if_entry = STAGE_EMPTY;
    if (bus.if_valid) begin
      if_entry.valid = 1'b1;
      if_entry.pc    = bus.if_pc;
      if (bus.if_misaligned) begin
        if_entry.exc  = 1'b1;
        if_entry.code = ECODE_INST_MISALIGNED;
      end else if (bus.if_fault) begin
        if_entry.exc  = 1'b1;
        if_entry.code = ECODE_INST_FAULT;
      end
    end
  end

  always_comb begin
    id_exc  = bus.id_illegal | bus.id_csr_illegal | bus.id_ebreak | bus.id_ecall;
    id_code = ecall_code(bus.prv);
    if (bus.id_illegal || bus.id_csr_illegal) id_code = ECODE_ILLEGAL;
    else if (bus.id_ebreak)                   id_code = ECODE_BREAKPOINT;
  end

  elbeth_exc_stage_reg u_id_reg (
    .clk        (clk),
    .rst        (rst),
    .stall      (bus.stall),
    .flush      (flush_s),
    .d_i        (if_entry),
    .add_exc_i  (1'b0),
    .add_code_i (4'd0),
    .add_eret_i (1'b0),
    .q_o        (id_q)
  );

  // Decode flags belong to the instruction sitting in ID and ride into EX with it.
  elbeth_exc_stage_reg u_ex_reg (
    .clk        (clk),
    .rst        (rst),
    .stall      (bus.stall),
    .flush      (flush_s),
    .d_i        (id_q),
    .add_exc_i  (id_exc),
    .add_code_i (id_code),
    .add_eret_i (bus.id_eret),
    .q_o        (ex_q)
  );

  elbeth_exc_stage_reg u_mem_reg (
    .clk        (clk),
    .rst        (rst),
    .stall      (bus.stall),
    .flush      (flush_s),
    .d_i        (ex_q),
    .add_exc_i  (1'b0),
    .add_code_i (4'd0),
    .add_eret_i (1'b0),
    .q_o        (mem_q)
  );

  // Data-side causes only apply when nothing older is already recorded.
  always_comb begin
    mem_exc  = mem_q.exc;
    mem_code = mem_q.code;
    if (mem_q.valid && !mem_q.exc) begin
      mem_exc = 1'b1;
      if (bus.mem_ld_misaligned)      mem_code = ECODE_LD_MISALIGNED;
      else if (bus.mem_ld_fault)      mem_code = ECODE_LD_FAULT;
      else if (bus.mem_st_misaligned) mem_code = ECODE_ST_MISALIGNED;
      else if (bus.mem_st_fault)      mem_code = ECODE_ST_FAULT;
      else                            mem_exc  = 1'b0;
    end
  end

`ifdef ELBETH_INTERRUPT_EN
  assign irq_req = bus.irq_pending;
`else
  logic unused_irq_pending;
  assign unused_irq_pending = bus.irq_pending;
  assign irq_req            = 1'b0;
`endif

  // CSR has already switched its privilege stack by the time REDIRECT samples these.
  assign target_pc = tgt_epc_q ? bus.epc : bus.handler_pc;

  // NOTE: every output and next-state variable gets a default first, so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    tgt_epc_d     = tgt_epc_q;
    redirect_pc_d = redirect_pc_q;
    exception_s   = 1'b0;
    interrupt_s   = 1'b0;
    eret_s        = 1'b0;
    retire_s      = 1'b0;
    flush_s       = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (mem_q.valid && !bus.stall) begin
          if (mem_exc) begin
            exception_s = 1'b1;
            flush_s     = 1'b1;
            tgt_epc_d   = 1'b0;
            state_d     = ST_REDIRECT;
          end else if (irq_req) begin
            interrupt_s = 1'b1;
            flush_s     = 1'b1;
            tgt_epc_d   = 1'b0;
            state_d     = ST_REDIRECT;
          end else if (mem_q.is_eret) begin
            eret_s    = 1'b1;
            retire_s  = 1'b1;
            flush_s   = 1'b1;
            tgt_epc_d = 1'b1;
            state_d   = ST_REDIRECT;
          end else begin
            retire_s = 1'b1;
          end
        end
      end
      ST_REDIRECT: begin
        flush_s       = 1'b1;
        redirect_pc_d = target_pc;
        state_d       = bus.if_ready ? ST_RUN : ST_HOLD;
      end
      ST_HOLD: begin
        flush_s = 1'b1;
        if (bus.if_ready) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      tgt_epc_q     <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      tgt_epc_q     <= tgt_epc_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign bus.exception           = exception_s;
  assign bus.interrupt_take      = interrupt_s;
  assign bus.eret                = eret_s;
  assign bus.retire              = retire_s;
  assign bus.flush               = flush_s;
  assign bus.exception_code      = mem_code;
  assign bus.exception_pc        = mem_q.pc;
  assign bus.exception_load_addr = is_data_cause(mem_code) ? bus.mem_addr : mem_q.pc;
  assign bus.redirect_valid      = (state_q != ST_RUN);
  // Live target on the first redirect cycle, frozen copy while fetch is not ready.
  assign bus.redirect_pc         = (state_q == ST_REDIRECT) ? target_pc : redirect_pc_q;

endmodule

// File: tb/tb_elbeth_exception_unit.sv
// Self-checking bench for elbeth_exception_unit: directed test-plan steps followed
// by randomized traffic, all compared against an instruction-level reference model.
module tb_elbeth_exception_unit;
  import elbeth_exception_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  elbeth_exception_unit_if bus ();

  elbeth_exception_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef ELBETH_INTERRUPT_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: instructions in ID (0), EX (1), MEM (2); cause -1 means none.
  bit          m_valid [3];
  int          m_cause [3];
  bit          m_eret  [3];
  logic [31:0] m_pc    [3];
  int          m_mode;     // 0 running, 1 first redirect cycle, 2 waiting for fetch
  bit          m_to_epc;
  logic [31:0] m_held;

  // Expectations of the current cycle, reused by advance()
  bit          e_exc, e_irq, e_eret, e_ret, e_flush;
  logic [31:0] e_rpc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_valid[i] = 1'b0;
      m_cause[i] = -1;
      m_eret[i]  = 1'b0;
      m_pc[i]    = '0;
    end
    m_mode   = 0;
    m_to_epc = 1'b0;
    m_held   = '0;
  endtask

  task automatic set_idle();
    bus.stall             = 1'b0;
    bus.if_valid          = 1'b0;
    bus.if_misaligned     = 1'b0;
    bus.if_fault          = 1'b0;
    bus.if_pc             = '0;
    bus.id_illegal        = 1'b0;
    bus.id_ecall          = 1'b0;
    bus.id_ebreak         = 1'b0;
    bus.id_eret           = 1'b0;
    bus.id_csr_illegal    = 1'b0;
    bus.mem_ld_misaligned = 1'b0;
    bus.mem_ld_fault      = 1'b0;
    bus.mem_st_misaligned = 1'b0;
    bus.mem_st_fault      = 1'b0;
    bus.mem_addr          = '0;
    bus.prv               = 2'd3;
    bus.irq_pending       = 1'b0;
    bus.handler_pc        = 32'h1C0;
    bus.epc               = 32'h300;
    bus.if_ready          = 1'b1;
  endtask

  // Called at posedge+1 with the cycle's inputs applied; checks at posedge+4.
  task automatic sample();
    int          cause;
    bit          take;
    logic [31:0] e_la;
    #3;
    cause = -1;
    if (m_valid[2]) begin
      cause = m_cause[2];
      if (cause < 0) begin
        if (bus.mem_ld_misaligned)      cause = 4;
        else if (bus.mem_ld_fault)      cause = 5;
        else if (bus.mem_st_misaligned) cause = 6;
        else if (bus.mem_st_fault)      cause = 7;
      end
    end
    take    = (m_mode == 0) && m_valid[2] && !bus.stall;
    e_exc   = take && (cause >= 0);
    e_irq   = take && (cause < 0) && IRQ_EN && bus.irq_pending;
    e_eret  = take && (cause < 0) && !e_irq && m_eret[2];
    e_ret   = take && (cause < 0) && !e_irq;
    e_flush = (m_mode != 0) || e_exc || e_irq || e_eret;
    e_rpc   = (m_mode == 1) ? (m_to_epc ? bus.epc : bus.handler_pc) : m_held;
    e_la    = (cause >= 4 && cause <= 7) ? bus.mem_addr : m_pc[2];

    check("exception", bus.exception, e_exc);
    check("interrupt_take", bus.interrupt_take, e_irq);
    check("eret", bus.eret, e_eret);
    check("retire", bus.retire, e_ret);
    check("flush", bus.flush, e_flush);
    check("redirect_valid", bus.redirect_valid, m_mode != 0);
    if (e_exc) begin
      check("exception_code", bus.exception_code, cause);
      check("exception_pc", bus.exception_pc, m_pc[2]);
      check("exception_load_addr", bus.exception_load_addr, e_la);
    end
    if (e_irq) check("irq_exception_pc", bus.exception_pc, m_pc[2]);
    if (m_mode != 0) check("redirect_pc", bus.redirect_pc, e_rpc);
  endtask

  task automatic advance();
    int cause;
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_mode == 0) begin
      if (e_exc || e_irq || e_eret) begin
        m_mode   = 1;
        m_to_epc = e_eret;
      end
    end else begin
      if (m_mode == 1) m_held = e_rpc;
      m_mode = bus.if_ready ? 0 : 2;
    end
    if (e_flush) begin
      for (int i = 0; i < 3; i++) begin
        m_valid[i] = 1'b0;
        m_cause[i] = -1;
        m_eret[i]  = 1'b0;
      end
    end else if (!bus.stall) begin
      m_valid[2] = m_valid[1];
      m_cause[2] = m_cause[1];
      m_eret[2]  = m_eret[1];
      m_pc[2]    = m_pc[1];
      cause = m_cause[0];
      if (m_valid[0] && cause < 0) begin
        if (bus.id_illegal || bus.id_csr_illegal) cause = 2;
        else if (bus.id_ebreak)                   cause = 3;
        else if (bus.id_ecall)                    cause = 8 + int'(bus.prv);
      end
      m_valid[1] = m_valid[0];
      m_cause[1] = m_valid[0] ? cause : -1;
      m_eret[1]  = m_valid[0] && bus.id_eret;
      m_pc[1]    = m_pc[0];
      m_valid[0] = bus.if_valid;
      m_pc[0]    = bus.if_pc;
      if (!bus.if_valid)          m_cause[0] = -1;
      else if (bus.if_misaligned) m_cause[0] = 0;
      else if (bus.if_fault)      m_cause[0] = 1;
      else                        m_cause[0] = -1;
      m_eret[0] = 1'b0;
    end
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic fetch(input logic [31:0] pc);
    set_idle();
    bus.if_valid = 1'b1;
    bus.if_pc    = pc;
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    sample();
    check("rst_exception_code", bus.exception_code, 0);
    check("rst_exception_pc", bus.exception_pc, 0);
    check("rst_load_addr", bus.exception_load_addr, 0);
    check("rst_redirect_pc", bus.redirect_pc, 0);
    advance();
    rst = 1'b0;

    // Illegal instruction at 0x100, then redirect to the handler
    fetch(32'h100); cycle();
    set_idle(); bus.id_illegal = 1'b1; cycle();
    set_idle(); cycle();
    sample();
    check("illegal_exc", bus.exception, 1);
    check("illegal_code", bus.exception_code, 2);
    check("illegal_pc", bus.exception_pc, 32'h100);
    advance();
    sample();
    check("illegal_redirect_pc", bus.redirect_pc, 32'h1C0);
    check("illegal_redirect_flush", bus.flush, 1);
    advance();

    // Load misaligned reports the data address
    fetch(32'h204); cycle();
    set_idle(); cycle();
    cycle();
    bus.mem_ld_misaligned = 1'b1;
    bus.mem_addr          = 32'h2003;
    sample();
    check("ldmis_code", bus.exception_code, 4);
    check("ldmis_addr", bus.exception_load_addr, 32'h2003);
    check("ldmis_retire", bus.retire, 0);
    advance();
    set_idle(); cycle();

    // IF fault beats a later illegal decode
    fetch(32'h280); bus.if_fault = 1'b1; cycle();
    set_idle(); bus.id_illegal = 1'b1; cycle();
    set_idle(); cycle();
    sample();
    check("first_cause_code", bus.exception_code, 1);
    advance();
    cycle();

    // Eret returns to epc
    fetch(32'h3F0); cycle();
    set_idle(); bus.id_eret = 1'b1; cycle();
    set_idle(); cycle();
    sample();
    check("eret_strobe", bus.eret, 1);
    check("eret_retire", bus.retire, 1);
    advance();
    sample();
    check("eret_redirect_pc", bus.redirect_pc, 32'h300);
    check("eret_one_cycle", bus.eret, 0);
    advance();

    // Interrupt against an instruction at 0x40, after a bubble with irq pending
    set_idle(); bus.irq_pending = 1'b1; cycle(); cycle();
    fetch(32'h40); bus.irq_pending = 1'b1; cycle();
    set_idle(); bus.irq_pending = 1'b1; cycle(); cycle();
    sample();
`ifdef ELBETH_INTERRUPT_EN
    check("irq_take", bus.interrupt_take, 1);
    check("irq_pc", bus.exception_pc, 32'h40);
    check("irq_no_retire", bus.retire, 0);
`else
    check("irq_ignored_retire", bus.retire, 1);
    check("irq_ignored_take", bus.interrupt_take, 0);
`endif
    advance();
    set_idle(); cycle(); cycle();

    // Redirect held while fetch is not ready, then reset during HOLD
    fetch(32'h500); bus.if_misaligned = 1'b1; cycle();
    set_idle(); cycle(); cycle();
    bus.if_ready = 1'b0;
    sample();
    check("hold_trap_code", bus.exception_code, 0);
    advance();
    cycle();
    bus.handler_pc = 32'h999;
    sample();
    check("hold_redirect_pc", bus.redirect_pc, 32'h1C0);
    check("hold_valid", bus.redirect_valid, 1);
    advance();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    sample();
    check("post_rst_redirect_valid", bus.redirect_valid, 0);
    check("post_rst_flush", bus.flush, 0);
    advance();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.stall             = ($urandom_range(0, 9) == 0);
      bus.if_valid          = ($urandom_range(0, 3) != 0);
      bus.if_pc             = $urandom;
      bus.if_misaligned     = ($urandom_range(0, 29) == 0);
      bus.if_fault          = ($urandom_range(0, 29) == 0);
      bus.id_illegal        = ($urandom_range(0, 39) == 0);
      bus.id_csr_illegal    = ($urandom_range(0, 39) == 0);
      bus.id_ebreak         = ($urandom_range(0, 39) == 0);
      bus.id_ecall          = ($urandom_range(0, 39) == 0);
      bus.id_eret           = ($urandom_range(0, 19) == 0);
      bus.mem_ld_misaligned = ($urandom_range(0, 39) == 0);
      bus.mem_ld_fault      = ($urandom_range(0, 39) == 0);
      bus.mem_st_misaligned = ($urandom_range(0, 39) == 0);
      bus.mem_st_fault      = ($urandom_range(0, 39) == 0);
      bus.mem_addr          = $urandom;
      case ($urandom_range(0, 2))
        0:       bus.prv = 2'd0;
        1:       bus.prv = 2'd1;
        default: bus.prv = 2'd3;
      endcase
      bus.irq_pending = ($urandom_range(0, 14) == 0);
      bus.handler_pc  = $urandom;
      bus.epc         = $urandom;
      bus.if_ready    = ($urandom_range(0, 2) != 0);
      rst             = ($urandom_range(0, 299) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
